// File: rtl/pb_debounce_if.sv
// Pushbutton conditioning bus.
//   pb_raw     : raw, asynchronous, bouncing button lines (active-high)
//   pb_level   : debounced button state
//   pb_press   : one-cycle pulse per accepted press and per repeat
//   pb_release : one-cycle pulse per accepted release
// master drives the raw lines and consumes the conditioned outputs;
// slave is the conditioning block itself.
interface pb_debounce_if #(
  parameter int WIDTH = 5
);
  logic [WIDTH-1:0] pb_raw;
  logic [WIDTH-1:0] pb_level;
  logic [WIDTH-1:0] pb_press;
  logic [WIDTH-1:0] pb_release;

  modport master (
    output pb_raw,
    input  pb_level,
    input  pb_press,
    input  pb_release
  );

  modport slave (
    input  pb_raw,
    output pb_level,
    output pb_press,
    output pb_release
  );
endinterface

// File: rtl/pb_debounce.sv
// Pushbutton front end: per-button 2-flop synchronizer, debounce counter,
// clean level, press/release pulses and optional hold-to-repeat presses.
// Every button is an independent copy of the same logic.
// Ports:
//   clk : system clock (single domain)
//   rst : synchronous reset, active-high
//   bus : pb_debounce_if slave (pb_raw in; pb_level, pb_press, pb_release out)
module pb_debounce #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic         clk,
  input  logic         rst,
  pb_debounce_if.slave bus
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W  = $clog2(RPT_MAX) + 1;

  localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RD_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RP_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, RPT} rpt_state_t;

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] level_p2;
  logic [WIDTH-1:0] press_p2;
  logic [WIDTH-1:0] release_p2;

  // Stage 0/1: two-flop synchronizer on the asynchronous raw lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.pb_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: debounce, repeat FSM and registered outputs, per button.
  for (genvar i = 0; i < WIDTH; i++) begin : g_btn
    logic [CNT_W-1:0]  cnt_p2;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [RCNT_W-1:0] rcnt_p2;
    logic [RCNT_W-1:0] rcnt_nxt;
    rpt_state_t        state_p2;
    rpt_state_t        state_nxt;
    logic              level_r;
    logic              press_r;
    logic              release_r;
    logic              level_nxt;
    logic              accept_rise;
    logic              accept_fall;
    logic              rpt_pulse;

    // Any sample matching the accepted level restarts the count, so only an
    // unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
    always_comb begin
      cnt_nxt     = cnt_p2 + 1'b1;
      level_nxt   = level_r;
      accept_rise = 1'b0;
      accept_fall = 1'b0;
      if (sync_p1[i] == level_r) begin
        cnt_nxt = '0;
      end else if (cnt_p2 == DB_LAST) begin
        cnt_nxt     = '0;
        level_nxt   = sync_p1[i];
        accept_rise = sync_p1[i];
        accept_fall = ~sync_p1[i];
      end
    end

    always_comb begin
      state_nxt = state_p2;
      rcnt_nxt  = rcnt_p2;
      rpt_pulse = 1'b0;
      case (state_p2)
        IDLE: begin
          if (accept_rise && (REPEAT_EN != 0)) begin
            state_nxt = DELAY;
            rcnt_nxt  = '0;
          end
        end
        DELAY: begin
          if (rcnt_p2 == RD_LAST) begin
            rpt_pulse = 1'b1;
            state_nxt = RPT;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt_p2 + 1'b1;
          end
        end
        RPT: begin
          if (rcnt_p2 == RP_LAST) begin
            rpt_pulse = 1'b1;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt_p2 + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end
      endcase
      // A release landing on a repeat terminal count suppresses that repeat.
      if (accept_fall) begin
        state_nxt = IDLE;
        rcnt_nxt  = '0;
        rpt_pulse = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_p2    <= '0;
        rcnt_p2   <= '0;
        state_p2  <= IDLE;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        cnt_p2    <= cnt_nxt;
        rcnt_p2   <= rcnt_nxt;
        state_p2  <= state_nxt;
        level_r   <= level_nxt;
        press_r   <= accept_rise | rpt_pulse;
        release_r <= accept_fall;
      end
    end

    assign level_p2[i]   = level_r;
    assign press_p2[i]   = press_r;
    assign release_p2[i] = release_r;
  end

  assign bus.pb_level   = level_p2;
  assign bus.pb_press   = press_p2;
  assign bus.pb_release = release_p2;

endmodule

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce: two builds (repeat enabled / disabled) share one
// stimulus stream. A spec-level model pushes expected outputs per clock edge;
// an independent monitor pops and compares just after each rising edge.
module tb_pb_debounce;
  localparam int W  = 5;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic clk;
  logic rst;

  pb_debounce_if #(.WIDTH(W)) bus_a ();
  pb_debounce_if #(.WIDTH(W)) bus_b ();

  pb_debounce #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  pb_debounce #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] lvl;
    logic [W-1:0] prs_a;
    logic [W-1:0] prs_b;
    logic [W-1:0] rel;
    int           edge_no;
  } exp_t;

  exp_t exp_q[$];
  int vectors;
  int miscompares;
  int edge_cnt;

  // Model state: effective raw values seen at the last D+1 edges
  // (index 0 = most recent), accepted level, edges since accepted press.
  logic [W-1:0] m_hist [0:D];
  logic [W-1:0] m_level;
  int           m_age [W];

  // Expected outputs after the upcoming rising edge. A new value is accepted
  // when the synchronized samples used at this edge and the D-1 before it
  // (raw from 2..D+1 edges ago) all differ from the current level.
  task automatic model_edge(input logic [W-1:0] raw, input logic r);
    exp_t e;
    logic stable;
    e.lvl = '0; e.prs_a = '0; e.prs_b = '0; e.rel = '0;
    e.edge_no = edge_cnt;
    if (r) begin
      for (int j = 0; j <= D; j++) m_hist[j] = '0;
      m_level = '0;
      for (int b = 0; b < W; b++) m_age[b] = 0;
    end else begin
      for (int b = 0; b < W; b++) begin
        stable = 1'b1;
        for (int j = 1; j <= D; j++)
          if (m_hist[j][b] == m_level[b]) stable = 1'b0;
        if (stable) begin
          m_level[b] = ~m_level[b];
          if (m_level[b]) begin
            e.prs_a[b] = 1'b1;
            e.prs_b[b] = 1'b1;
            m_age[b]   = 0;
          end else begin
            e.rel[b] = 1'b1;
          end
        end else if (m_level[b]) begin
          m_age[b]++;
          if (m_age[b] == RD || (m_age[b] > RD && ((m_age[b] - RD) % RP) == 0))
            e.prs_a[b] = 1'b1;
        end
      end
      for (int j = D; j >= 1; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = raw;
    end
    e.lvl = m_level;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [W-1:0] raw, input logic r);
    @(negedge clk);
    bus_a.pb_raw = raw;
    bus_b.pb_raw = raw;
    rst = r;
    edge_cnt++;
    model_edge(raw, r);
  endtask

  task automatic check(input string name, input int edge_no,
                       input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s edge %0d: got %b, expected %b", name, edge_no, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("a_level",   e.edge_no, bus_a.pb_level,   e.lvl);
        check("a_press",   e.edge_no, bus_a.pb_press,   e.prs_a);
        check("a_release", e.edge_no, bus_a.pb_release, e.rel);
        check("b_level",   e.edge_no, bus_b.pb_level,   e.lvl);
        check("b_press",   e.edge_no, bus_b.pb_press,   e.prs_b);
        check("b_release", e.edge_no, bus_b.pb_release, e.rel);
      end
    end
  end

  initial begin
    logic [W-1:0] raw;
    int hold;
    vectors = 0;
    miscompares = 0;
    edge_cnt = 0;
    rst = 1'b1;
    bus_a.pb_raw = '0;
    bus_b.pb_raw = '0;
    for (int j = 0; j <= D; j++) m_hist[j] = '0;
    m_level = '0;
    for (int b = 0; b < W; b++) m_age[b] = 0;

    // Reset with all buttons held, then release reset while still held.
    repeat (3) step(5'b11111, 1'b1);
    repeat (8) step(5'b11111, 1'b0);
    repeat (10) step(5'b00000, 1'b0);

    // Clean press/release on bit 0 (repeats while held).
    repeat (20) step(5'b00001, 1'b0);
    repeat (10) step(5'b00000, 1'b0);

    // Bounce on bit 2 (runs of 3 rejected), then a run of exactly 4 accepted.
    repeat (3) step(5'b00100, 1'b0);
    step(5'b00000, 1'b0);
    repeat (3) step(5'b00100, 1'b0);
    repeat (8) step(5'b00000, 1'b0);
    repeat (4) step(5'b00100, 1'b0);
    repeat (8) step(5'b00000, 1'b0);

    // Bit 1 hold lengths; 11 and 14 land the release on a repeat terminal count.
    for (int k = 0; k < 3; k++) begin
      hold = (k == 0) ? 11 : (k == 1) ? 14 : 12;
      repeat (hold) step(5'b00010, 1'b0);
      repeat (12) step(5'b00000, 1'b0);
    end

    // Bits 3 and 4 pressed two cycles apart.
    repeat (2) step(5'b01000, 1'b0);
    repeat (10) step(5'b11000, 1'b0);
    repeat (2) step(5'b10000, 1'b0);
    repeat (10) step(5'b00000, 1'b0);

    // Long hold on bit 0: build b must show a single press.
    repeat (50) step(5'b00001, 1'b0);
    repeat (10) step(5'b00000, 1'b0);

    // Reset in the middle of a held, repeating button.
    repeat (15) step(5'b00001, 1'b0);
    repeat (2) step(5'b00001, 1'b1);
    repeat (15) step(5'b00001, 1'b0);
    repeat (10) step(5'b00000, 1'b0);

    // Random toggling: fast (glitchy) then slow (repeating) phases.
    raw = '0;
    for (int n = 0; n < 2400; n++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range((n < 1500) ? 4 : 15, 0) == 0) raw[b] = ~raw[b];
      step(raw, ($urandom_range(299, 0) == 0));
    end
    repeat (12) step(5'b00000, 1'b0);

    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
